// File: rtl/sd_dat_tx_if.sv
// Signal bundle between the host data buffer / controller and the SD DAT write framer.
// The master side owns the buffer and control; the slave side drives the DAT bus.
interface sd_dat_tx_if;
  logic        start;
  logic        abort;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_pop;
  logic [3:0]  dat_out;
  logic        dat_oe;
  logic        sd_clk_en;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, word_in, word_valid,
    input  word_pop, dat_out, dat_oe, sd_clk_en, busy, done
  );

  modport slave (
    input  start, abort, word_in, word_valid,
    output word_pop, dat_out, dat_oe, sd_clk_en, busy, done
  );
endinterface

// File: rtl/sd_dat_tx.sv
// SD 4-bit wide-bus write framer: start bit, block data popped from a 32-bit buffer,
// one CRC16 per DAT line, end bit. The card clock is gated while a needed word is missing.
module sd_dat_tx #(
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic       clk,
  input  logic       reset_n,
  sd_dat_tx_if.slave bus
);

  localparam int unsigned     NIBBLES  = 2 * BLOCK_BYTES;
  localparam int unsigned     NIB_W    = $clog2(NIBBLES);
  localparam int unsigned     CNT_W    = (NIB_W < 4) ? 4 : NIB_W;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(15);
  localparam logic [15:0]     CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      shift_q;
  logic [3:0][15:0] crc_q;
  logic [3:0]       dat_q;
  logic             dat_oe_q;
  logic             busy_q;
  logic             done_q;

  logic             need_word;
  logic             stall;
  logic [3:0][15:0] crc_d;

  // One step of the x^16+x^12+x^5+1 LFSR for a single serial data bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = d ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  // A word is needed to leave START, and at the last nibble of every word but the final one.
  assign need_word = (state_q == S_START) ||
                     ((state_q == S_DATA) && (cnt_q[2:0] == 3'd7) && (cnt_q != LAST_NIB));
  assign stall     = need_word && !bus.word_valid;

  // NOTE: pop and clock-enable are combinational on word_valid because the buffer word is
  // consumed in the very cycle it is offered; registering them would lose a cycle per word.
  assign bus.word_pop  = need_word && bus.word_valid;
  assign bus.sd_clk_en = !stall;

  assign bus.dat_out = dat_q;
  assign bus.dat_oe  = dat_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  // Each DAT line's CRC absorbs the nibble currently on the bus; bit i goes to line i.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      crc_d[i] = crc16_step(crc_q[i], shift_q[28 + i]);
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      crc_q    <= '0;
      dat_q    <= 4'hF;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.abort) begin
      state_q  <= S_IDLE;
      dat_q    <= 4'hF;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_START;
            cnt_q    <= '0;
            crc_q    <= '0;
            dat_q    <= 4'h0;
            dat_oe_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        S_START: begin
          if (!stall) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            shift_q <= bus.word_in;
            dat_q   <= bus.word_in[31:28];
          end
        end

        S_DATA: begin
          if (!stall) begin
            crc_q <= crc_d;
            if (cnt_q == LAST_NIB) begin
              state_q <= S_CRC;
              cnt_q   <= '0;
              for (int i = 0; i < 4; i++) begin
                dat_q[i] <= crc_d[i][15];
              end
            end else if (need_word) begin
              cnt_q   <= cnt_q + CNT_W'(1);
              shift_q <= bus.word_in;
              dat_q   <= bus.word_in[31:28];
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              shift_q <= {shift_q[27:0], 4'h0};
              dat_q   <= shift_q[27:24];
            end
          end
        end

        S_CRC: begin
          for (int i = 0; i < 4; i++) begin
            crc_q[i] <= {crc_q[i][14:0], 1'b0};
          end
          if (cnt_q == LAST_CRC) begin
            state_q <= S_END;
            dat_q   <= 4'hF;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int i = 0; i < 4; i++) begin
              dat_q[i] <= crc_q[i][14];
            end
          end
        end

        S_END: begin
          state_q  <= S_IDLE;
          dat_q    <= 4'hF;
          dat_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end

        default: begin
          state_q  <= S_IDLE;
          dat_q    <= 4'hF;
          dat_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Scoreboard bench for sd_dat_tx: three block sizes (512, 4, 8 bytes), random data,
// buffer stalls, abort, and reset. Expected DAT beats come from a polynomial-division model.
module tb_sd_dat_tx;

  typedef struct packed {
    logic [3:0] nib;
    logic       done;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        word_valid;
  logic [31:0] word_in;
  int          sel;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       exp_q[$];
  logic [31:0] src_q[$];
  logic        pop_flag = 1'b0;

  int cyc_cnt = 0;
  int t0 = 0;
  int pops_seen, done_seen, busy_cycles, stall_cycles, done_rel;

  logic [3:0] m_dat_out;
  logic       m_dat_oe, m_sd_clk_en, m_word_pop, m_busy, m_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  sd_dat_tx_if if0 ();
  sd_dat_tx_if if1 ();
  sd_dat_tx_if if2 ();

  assign if0.start      = start & (sel == 0);
  assign if1.start      = start & (sel == 1);
  assign if2.start      = start & (sel == 2);
  assign if0.abort      = abort & (sel == 0);
  assign if1.abort      = abort & (sel == 1);
  assign if2.abort      = abort & (sel == 2);
  assign if0.word_in    = word_in;
  assign if1.word_in    = word_in;
  assign if2.word_in    = word_in;
  assign if0.word_valid = word_valid;
  assign if1.word_valid = word_valid;
  assign if2.word_valid = word_valid;

  sd_dat_tx #(.BLOCK_BYTES(512)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  sd_dat_tx #(.BLOCK_BYTES(4))   u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  sd_dat_tx #(.BLOCK_BYTES(8))   u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

  always_comb begin
    m_dat_out   = if0.dat_out;
    m_dat_oe    = if0.dat_oe;
    m_sd_clk_en = if0.sd_clk_en;
    m_word_pop  = if0.word_pop;
    m_busy      = if0.busy;
    m_done      = if0.done;
    case (sel)
      1: begin
        m_dat_out = if1.dat_out; m_dat_oe = if1.dat_oe; m_sd_clk_en = if1.sd_clk_en;
        m_word_pop = if1.word_pop; m_busy = if1.busy; m_done = if1.done;
      end
      2: begin
        m_dat_out = if2.dat_out; m_dat_oe = if2.dat_oe; m_sd_clk_en = if2.sd_clk_en;
        m_word_pop = if2.word_pop; m_busy = if2.busy; m_done = if2.done;
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // CRC of one DAT line as the remainder of (line bits followed by 16 zeros) mod 0x11021.
  function automatic logic [15:0] line_crc(input logic [31:0] w[$], input int line);
    logic [16:0] r;
    logic        b;
    r = '0;
    for (int k = 0; k < w.size(); k++) begin
      for (int n = 7; n >= 0; n--) begin
        b = w[k][4*n + line];
        r = {r[15:0], b};
        if (r[16]) r = r ^ 17'h11021;
      end
    end
    for (int z = 0; z < 16; z++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  // Expected counted DAT beats of a block, truncated to the first 'keep' beats.
  task automatic push_frame(input logic [31:0] w[$], input int keep);
    logic [3:0]  beats[$];
    logic [15:0] crc[4];
    beat_t       bt;
    beats.push_back(4'h0);
    for (int k = 0; k < w.size(); k++)
      for (int n = 7; n >= 0; n--) beats.push_back(w[k][4*n +: 4]);
    for (int l = 0; l < 4; l++) crc[l] = line_crc(w, l);
    for (int b = 15; b >= 0; b--) beats.push_back({crc[3][b], crc[2][b], crc[1][b], crc[0][b]});
    beats.push_back(4'hF);
    for (int i = 0; i < beats.size() && i < keep; i++) begin
      bt.nib  = beats[i];
      bt.done = (i == beats.size() - 1);
      exp_q.push_back(bt);
    end
  endtask

  // Buffer model: pop observed in a cycle takes effect just after that cycle's edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_flag) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        pop_flag = 1'b0;
      end
      word_in = (src_q.size() > 0) ? src_q[0] : 32'h0;
    end
  end

  // Monitor: every counted beat with DAT driven is compared with the scoreboard head.
  always @(negedge clk) begin : mon
    beat_t e;
    if (reset_n) begin
      if (m_word_pop) begin
        pops_seen++;
        pop_flag = 1'b1;
      end
      if (m_busy) busy_cycles++;
      if (m_done) begin
        done_seen++;
        done_rel = cyc_cnt - t0;
      end
      if (m_busy && !m_sd_clk_en) begin
        stall_cycles++;
        check("stall_pop", 32'(m_word_pop), 32'd0);
        if (exp_q.size() > 0) check("stall_hold", 32'(m_dat_out), 32'(exp_q[0].nib));
      end
      if (m_dat_oe && m_sd_clk_en) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("dat_out", 32'(m_dat_out), 32'(e.nib));
          check("done", 32'(m_done), 32'(e.done));
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_dat_out"},   32'(m_dat_out),   32'hF);
    check({tag, "_dat_oe"},    32'(m_dat_oe),    32'd0);
    check({tag, "_sd_clk_en"}, 32'(m_sd_clk_en), 32'd1);
    check({tag, "_word_pop"},  32'(m_word_pop),  32'd0);
    check({tag, "_busy"},      32'(m_busy),      32'd0);
    check({tag, "_done"},      32'(m_done),      32'd0);
  endtask

  // mode: 0 all-zero words, 1 first word 0x12345678 then random, 2 random.
  // word_valid is low for block-relative cycles [vfrom, vfrom+vlen); rel 0 is the start cycle.
  task automatic run_block(input int s, input int bytes, input int mode, input int vfrom,
                           input int vlen, input int abort_rel, input int bstart_rel,
                           input int rst_rel);
    logic [31:0] w[$];
    logic [31:0] v;
    int nw, rel, limit, data_end, keep, last_rel, exp_pops, exp_busy;
    nw = bytes / 4;
    sel = s;
    src_q.delete();
    exp_q.delete();
    for (int k = 0; k < nw; k++) begin
      if (mode == 0) v = 32'h0;
      else if (mode == 1 && k == 0) v = 32'h1234_5678;
      else v = $urandom;
      w.push_back(v);
      src_q.push_back(v);
    end
    if (abort_rel > 0) begin
      keep = abort_rel; last_rel = abort_rel; exp_busy = abort_rel;
    end else if (rst_rel > 0) begin
      keep = rst_rel - 1; last_rel = rst_rel - 1; exp_busy = rst_rel - 1;
    end else begin
      keep = 1 << 30; last_rel = 1 << 30; exp_busy = 2 * bytes + 18 + vlen;
    end
    exp_pops = 0;
    for (int j = 0; j < nw; j++)
      if (((j == 0) ? 1 : 8 * j + 1) <= last_rel) exp_pops++;
    push_frame(w, keep);

    pops_seen = 0; done_seen = 0; busy_cycles = 0; stall_cycles = 0; done_rel = -1;
    limit    = 2 * bytes + 18 + vlen + 8;
    data_end = 1 + 2 * bytes + vlen;
    word_in    = src_q[0];
    word_valid = !(vlen > 0 && vfrom == 0);
    start      = 1'b1;
    t0  = cyc_cnt;
    rel = 0;
    while (1) begin
      cyc(1);
      rel++;
      start = (rel == bstart_rel);
      abort = (rel == abort_rel);
      if (rel >= vfrom && rel < vfrom + vlen) word_valid = 1'b0;
      else if (rel > data_end) word_valid = 1'($urandom);
      else word_valid = 1'b1;
      if (rel == rst_rel) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("midblock_reset");
        cyc(1);
        reset_n = 1'b1;
        break;
      end
      if (abort_rel > 0 && rel == abort_rel + 1) begin
        check("abort_dat_oe", 32'(m_dat_oe), 32'd0);
        check("abort_busy",   32'(m_busy),   32'd0);
      end
      if ((rel >= 2 && !m_busy) || rel > limit) break;
    end
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b1;
    check("block_timeout", 32'(rel > limit), 32'd0);
    cyc(3);
    check("idle_after_block", 32'(m_busy), 32'd0);
    check("beats_left",   32'(exp_q.size()), 32'd0);
    check("pop_count",    32'(pops_seen),    32'(exp_pops));
    check("busy_cycles",  32'(busy_cycles),  32'(exp_busy));
    check("stall_cycles", 32'(stall_cycles), 32'(vlen));
    if (abort_rel > 0 || rst_rel > 0) begin
      check("done_count", 32'(done_seen), 32'd0);
    end else begin
      check("done_count", 32'(done_seen), 32'd1);
      check("end_cycle",  32'(done_rel),  32'(2 * bytes + 18 + vlen));
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = '0; sel = 0;
    cyc(2);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_reset("reset");
    end
    reset_n = 1'b1;
    word_valid = 1'b1;
    cyc(2);

    // 512-byte all-zero block, buffer always ready.
    run_block(0, 512, 0, 0, 0, 0, 0, 0);
    // 4-byte block of 0x12345678, with an ignored start while busy.
    run_block(1, 4, 1, 0, 0, 0, 12, 0);
    // 8-byte block, buffer empty for 3 cycles at nibble 7 of word 0.
    run_block(2, 8, 1, 9, 3, 0, 0, 0);
    // Buffer empty for 5 cycles in START.
    run_block(2, 8, 2, 1, 5, 0, 0, 0);
    // Abort on data nibble 100, then a fresh block.
    run_block(0, 512, 2, 0, 0, 102, 0, 0);
    run_block(0, 512, 2, 0, 0, 0, 0, 0);

    // start and abort together in IDLE: abort wins.
    sel = 1;
    start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy",   32'(m_busy),   32'd0);
    check("abort_start_dat_oe", 32'(m_dat_oe), 32'd0);
    cyc(2);
    check("abort_start_idle",   32'(m_busy),   32'd0);

    // Reset during CRC, preceded by a start while busy.
    run_block(1, 4, 2, 0, 0, 0, 5, 15);

    // Random data with a random stall at a word boundary.
    for (int r = 0; r < 3; r++) begin
      int j, len;
      j   = int'($urandom_range(0, 126));
      len = int'($urandom_range(1, 4));
      run_block(0, 512, 2, 9 + 8 * j, len, 0, 0, 0);
    end
    run_block(1, 4, 2, 0, 0, 0, 0, 0);
    run_block(2, 8, 2, 1, 2, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_dat_tx.md
Name: sd_dat_tx

Overview:
- Write-path DAT line framer between the host data buffer/FIFO and the SD card's 4-bit DAT bus.
- Pops 32-bit words from the buffer and serializes them as one SD wide-bus data block.
- Frame: start bit, data nibbles, 16-bit CRC per DAT line, end bit.
- Drives DAT output enable and a card-clock enable; the card clock stalls while the buffer has no word ready.

Parameters:
- BLOCK_BYTES, 512, data bytes per block; multiple of 4, range 4..2048.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send one block; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- word_in  in  32  buffer data; valid when word_valid=1.
- word_valid  in  1  buffer non-empty.
- word_pop  out  1  one-cycle pop; word_in is consumed in that cycle.
- dat_out  out  4  DAT[3:0] drive value.
- dat_oe  out  1  DAT output enable.
- sd_clk_en  out  1  card clock enable; 0 = card clock stopped this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the END-bit cycle.

Behaviour:
Reset values (async, reset_n=0):
- State=IDLE, dat_out=4'hF, dat_oe=0, sd_clk_en=1, word_pop=0, busy=0, done=0.
- CRC registers, shift register and counters cleared.

Stall and counting rules:
- A cycle "counts" only when sd_clk_en=1. State, counters and CRC advance only in counting cycles.
- sd_clk_en=0 only when a word is needed (START, or last nibble of a word with words remaining) and word_valid=0.
- During a stall: dat_out holds its value and word_pop=0.

States:
- IDLE: dat_oe=0, dat_out=F. start=1 -> START next cycle. start while busy is ignored.
- START: dat_oe=1, dat_out=4'b0000.
  - If word_valid=1: word_pop=1, latch word_in into the shift register, -> DATA.
  - Else stall in START.
- DATA: dat_out=shift[31:28]; shift left 4 each counting cycle.
  - Byte order is word_in[31:24] first, high nibble first; DAT3 carries bit 7/3 of each byte.
  - Nibble counter runs 0..2*BLOCK_BYTES-1.
  - On nibble 7 of a word with more words remaining: needs word_valid=1. If so, word_pop=1 and the next word loads; else stall.
  - After the last nibble (no pop) -> CRC.
- CRC: 16 cycles. dat_out[i]=crc_i[15], crc_i shifts left with 0 fill. The CRC is never stalled. -> END.
- END: dat_out=4'hF, dat_oe=1, done=1 for 1 cycle. -> IDLE; dat_oe drops next cycle.

CRC rules:
- Four independent CRC16 generators, one per DAT line.
- Polynomial x^16+x^12+x^5+1, init 0x0000.
- Fed with data bits only, in transmit order.
- Cleared on entry to START.

Timing:
- Unstalled latency: start at cycle T -> START at T+1, DATA T+2..T+1+2*BLOCK_BYTES, CRC next 16, END at T+18+2*BLOCK_BYTES.
- Exactly BLOCK_BYTES/4 pops per block, never more.

Boundary conditions:
- abort in any state: next cycle IDLE, dat_oe=0, no done, no further pops. An abort in the same cycle as a pop still consumes that word.
- abort and start together in IDLE: abort wins; the block stays in IDLE.
- reset_n low mid-block: immediate return to reset values; the partial block is discarded.
- word_valid toggling during CRC/END: ignored.
- BLOCK_BYTES=4: a single word, pop only in START.

Test Plan:
- BLOCK_BYTES=512, FIFO always valid, all words 0x00000000, start pulse:
  - START at T+1 with dat_out=0, dat_oe=1; 1024 data cycles of 0.
  - 16 CRC cycles of 0 (CRC=0x0000 all lines); END=F at T+1042; done=1 once; 128 pops.
- BLOCK_BYTES=4, word 0x12345678:
  - DATA nibbles 1,2,3,4,5,6,7,8 on consecutive cycles.
  - CRC per line matches the bench model.
  - Total busy = 1+8+16+1 = 26 cycles.
- BLOCK_BYTES=8, word_valid dropped for 3 cycles at nibble 7 of word 0:
  - sd_clk_en=0 for exactly 3 cycles; dat_out holds 4'h8 (for word 0x12345678).
  - CRC is identical to the unstalled run.
- word_valid=0 at START for 5 cycles:
  - dat_out=0 held, sd_clk_en=0 for 5 cycles, no pop.
  - Then normal frame.
- abort asserted at data nibble 100:
  - Next cycle IDLE, dat_oe=0, no done.
  - Pops stop; total pops = 13 (words 0..12).
  - A new start sends a fresh block with the correct CRC.
- reset_n pulsed low during the CRC phase:
  - Outputs immediately take reset values.
  - start while busy, issued before the reset, has no effect.
